// File: rtl/pixel_accum_if.sv
// Sample-stream and pixel-stream bundle for pixel_accum.
// The master side produces samples and consumes pixels; the slave side is the accumulator.
interface pixel_accum_if #(
  parameter int LOG2_SPP = 2,
  parameter int IMG_W    = 240,
  parameter int IMG_H    = 240
);
  localparam int PX_WIDTH  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int PY_WIDTH  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int RPP_WIDTH = (LOG2_SPP > 0) ? LOG2_SPP : 1;

  logic                 in_vld;
  logic                 in_rdy;
  logic [PX_WIDTH-1:0]  in_x;
  logic [PY_WIDTH-1:0]  in_y;
  logic [RPP_WIDTH-1:0] in_s;
  logic [15:0]          in_r;
  logic [15:0]          in_g;
  logic [15:0]          in_b;

  logic                 out_vld;
  logic                 out_rdy;
  logic [PX_WIDTH-1:0]  out_x;
  logic [PY_WIDTH-1:0]  out_y;
  logic [23:0]          out_rgb;

  logic                 seq_err;
  logic                 frame_done;

  modport master (
    output in_vld, in_x, in_y, in_s, in_r, in_g, in_b, out_rdy,
    input  in_rdy, out_vld, out_x, out_y, out_rgb, seq_err, frame_done
  );

  modport slave (
    input  in_vld, in_x, in_y, in_s, in_r, in_g, in_b, out_rdy,
    output in_rdy, out_vld, out_x, out_y, out_rgb, seq_err, frame_done
  );
endinterface

// File: rtl/pixel_accum.sv
// Sums SPP shaded samples per pixel, box-filters and quantises to 8-bit RGB, and
// buffers finished pixels in a 2-entry FIFO; flags out-of-order streams and frame end.
module pixel_accum #(
  parameter int LOG2_SPP = 2,
  parameter int IMG_W    = 240,
  parameter int IMG_H    = 240
) (
  input logic          clk,
  input logic          rst_n,
  pixel_accum_if.slave bus
);
  localparam int SPP       = 1 << LOG2_SPP;
  localparam int PX_WIDTH  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int PY_WIDTH  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int RPP_WIDTH = (LOG2_SPP > 0) ? LOG2_SPP : 1;
  localparam int SUM_W     = 16 + LOG2_SPP;

  localparam logic [RPP_WIDTH-1:0] S_ZERO = {RPP_WIDTH{1'b0}};
  localparam logic [RPP_WIDTH-1:0] S_ONE  = RPP_WIDTH'(1);
  localparam logic [RPP_WIDTH-1:0] S_LAST = RPP_WIDTH'(SPP - 1);
  localparam logic [PX_WIDTH-1:0]  X_LAST = PX_WIDTH'(IMG_W - 1);
  localparam logic [PY_WIDTH-1:0]  Y_LAST = PY_WIDTH'(IMG_H - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Averages at or above 1.0 saturate; below that keep bits [14:7] (truncating).
  function automatic logic [7:0] quant(input logic [15:0] avg);
    if (avg[15]) begin
      quant = 8'hFF;
    end else begin
      quant = avg[14:7];
    end
  endfunction

  state_t               state_r;
  logic [RPP_WIDTH-1:0] cnt_r;
  logic [PX_WIDTH-1:0]  px_r;
  logic [PY_WIDTH-1:0]  py_r;
  logic [SUM_W-1:0]     acc_r_r;
  logic [SUM_W-1:0]     acc_g_r;
  logic [SUM_W-1:0]     acc_b_r;
  logic                 seq_err_r;

  logic [1:0]           fifo_cnt_r;
  logic                 out_vld_r;
  logic [PX_WIDTH-1:0]  head_x_r;
  logic [PY_WIDTH-1:0]  head_y_r;
  logic [23:0]          head_rgb_r;
  logic [PX_WIDTH-1:0]  tail_x_r;
  logic [PY_WIDTH-1:0]  tail_y_r;
  logic [23:0]          tail_rgb_r;
  logic                 frame_done_r;

  logic                 in_rdy_s;
  logic                 accept_s;
  logic                 match_s;
  logic                 last_s;
  logic                 push_s;
  logic                 pop_s;
  logic [SUM_W-1:0]     base_r_s;
  logic [SUM_W-1:0]     base_g_s;
  logic [SUM_W-1:0]     base_b_s;
  logic [SUM_W-1:0]     sum_r_s;
  logic [SUM_W-1:0]     sum_g_s;
  logic [SUM_W-1:0]     sum_b_s;
  logic [23:0]          push_rgb_s;

  // Sample acceptance, sequence matching and the filtered/quantised pixel value.
  always_comb begin
    in_rdy_s = (fifo_cnt_r < 2'd2);
    accept_s = bus.in_vld && in_rdy_s;
    last_s   = (bus.in_s == S_LAST);
    pop_s    = out_vld_r && bus.out_rdy;
    case (state_r)
      ST_EMPTY: begin
        match_s  = (bus.in_s == S_ZERO);
        base_r_s = {SUM_W{1'b0}};
        base_g_s = {SUM_W{1'b0}};
        base_b_s = {SUM_W{1'b0}};
      end
      ST_ACCUM: begin
        match_s  = (bus.in_s == cnt_r) && (bus.in_x == px_r) && (bus.in_y == py_r);
        base_r_s = acc_r_r;
        base_g_s = acc_g_r;
        base_b_s = acc_b_r;
      end
      default: begin
        match_s  = 1'b0;
        base_r_s = {SUM_W{1'b0}};
        base_g_s = {SUM_W{1'b0}};
        base_b_s = {SUM_W{1'b0}};
      end
    endcase
    sum_r_s    = base_r_s + SUM_W'(bus.in_r);
    sum_g_s    = base_g_s + SUM_W'(bus.in_g);
    sum_b_s    = base_b_s + SUM_W'(bus.in_b);
    // Top 16 bits of the sum are the sum shifted right by LOG2_SPP.
    push_rgb_s = {quant(sum_r_s[SUM_W-1 -: 16]),
                  quant(sum_g_s[SUM_W-1 -: 16]),
                  quant(sum_b_s[SUM_W-1 -: 16])};
    push_s     = accept_s && match_s && last_s;
  end

  // Accumulator FSM: sample counting, coordinate latch, partial sums and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_EMPTY;
      cnt_r     <= S_ZERO;
      px_r      <= {PX_WIDTH{1'b0}};
      py_r      <= {PY_WIDTH{1'b0}};
      acc_r_r   <= {SUM_W{1'b0}};
      acc_g_r   <= {SUM_W{1'b0}};
      acc_b_r   <= {SUM_W{1'b0}};
      seq_err_r <= 1'b0;
    end else if (accept_s) begin
      if (match_s) begin
        if (last_s) begin
          state_r <= ST_EMPTY;
          cnt_r   <= S_ZERO;
        end else begin
          state_r <= ST_ACCUM;
          cnt_r   <= cnt_r + S_ONE;
          px_r    <= bus.in_x;
          py_r    <= bus.in_y;
          acc_r_r <= sum_r_s;
          acc_g_r <= sum_g_s;
          acc_b_r <= sum_b_s;
        end
      end else begin
        seq_err_r <= 1'b1;
        // A stray index-0 sample is the start of a fresh pixel; anything else is dropped.
        if (bus.in_s == S_ZERO) begin
          state_r <= ST_ACCUM;
          cnt_r   <= S_ONE;
          px_r    <= bus.in_x;
          py_r    <= bus.in_y;
          acc_r_r <= SUM_W'(bus.in_r);
          acc_g_r <= SUM_W'(bus.in_g);
          acc_b_r <= SUM_W'(bus.in_b);
        end else begin
          state_r <= ST_EMPTY;
          cnt_r   <= S_ZERO;
        end
      end
    end else begin
      state_r <= state_r;
    end
  end

  // Two-entry output FIFO with a registered head feeding the pixel port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt_r <= 2'd0;
      out_vld_r  <= 1'b0;
      head_x_r   <= {PX_WIDTH{1'b0}};
      head_y_r   <= {PY_WIDTH{1'b0}};
      head_rgb_r <= 24'h000000;
      tail_x_r   <= {PX_WIDTH{1'b0}};
      tail_y_r   <= {PY_WIDTH{1'b0}};
      tail_rgb_r <= 24'h000000;
    end else begin
      case (fifo_cnt_r)
        2'd0: begin
          if (push_s) begin
            head_x_r   <= bus.in_x;
            head_y_r   <= bus.in_y;
            head_rgb_r <= push_rgb_s;
            fifo_cnt_r <= 2'd1;
            out_vld_r  <= 1'b1;
          end else begin
            out_vld_r  <= 1'b0;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            head_x_r   <= bus.in_x;
            head_y_r   <= bus.in_y;
            head_rgb_r <= push_rgb_s;
          end else if (push_s) begin
            tail_x_r   <= bus.in_x;
            tail_y_r   <= bus.in_y;
            tail_rgb_r <= push_rgb_s;
            fifo_cnt_r <= 2'd2;
          end else if (pop_s) begin
            fifo_cnt_r <= 2'd0;
            out_vld_r  <= 1'b0;
          end else begin
            out_vld_r  <= 1'b1;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_x_r   <= tail_x_r;
            head_y_r   <= tail_y_r;
            head_rgb_r <= tail_rgb_r;
            if (push_s) begin
              tail_x_r   <= bus.in_x;
              tail_y_r   <= bus.in_y;
              tail_rgb_r <= push_rgb_s;
            end else begin
              fifo_cnt_r <= 2'd1;
            end
          end else begin
            out_vld_r <= 1'b1;
          end
        end
        default: begin
          fifo_cnt_r <= 2'd0;
          out_vld_r  <= 1'b0;
        end
      endcase
    end
  end

  // End-of-frame pulse, one cycle after the bottom-right pixel leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= pop_s && (head_x_r == X_LAST) && (head_y_r == Y_LAST);
    end
  end

  assign bus.in_rdy     = in_rdy_s;
  assign bus.out_vld    = out_vld_r;
  assign bus.out_x      = head_x_r;
  assign bus.out_y      = head_y_r;
  assign bus.out_rgb    = head_rgb_r;
  assign bus.seq_err    = seq_err_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_pixel_accum.sv
// Directed bench for pixel_accum: a 240x240 instance for averaging, clamping, backpressure,
// sequence errors and reset, plus a 4x2 instance for the end-of-frame pulse.
module tb_pixel_accum;
  logic clk;
  logic rst_n;

  pixel_accum_if #(.LOG2_SPP(2), .IMG_W(240), .IMG_H(240)) bus_a ();
  pixel_accum_if #(.LOG2_SPP(2), .IMG_W(4),   .IMG_H(2))   bus_f ();

  pixel_accum #(.LOG2_SPP(2), .IMG_W(240), .IMG_H(240)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  pixel_accum #(.LOG2_SPP(2), .IMG_W(4), .IMG_H(2)) dut_f (
    .clk(clk), .rst_n(rst_n), .bus(bus_f.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       x;
    logic [7:0]       y;
    logic [3:0][15:0] r;
    logic [3:0][15:0] g;
    logic [3:0][15:0] b;
    logic [23:0]      rgb;
  } pix_t;

  pix_t        tbl [4];
  logic [39:0] got_a [$];
  int          got_f_cnt = 0;
  logic [23:0] got_f_last = 24'h0;
  int          fd_cnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  // Output-transfer monitors, sampled half a cycle before the transferring edge.
  always @(negedge clk) begin
    if (bus_a.out_vld && bus_a.out_rdy) got_a.push_back({bus_a.out_x, bus_a.out_y, bus_a.out_rgb});
    if (bus_f.out_vld && bus_f.out_rdy) begin
      got_f_cnt++;
      got_f_last = bus_f.out_rgb;
    end
    if (bus_f.frame_done) fd_cnt++;
  end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic send_a(input logic [7:0] x, input logic [7:0] y, input logic [1:0] s,
                        input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
    int n;
    bus_a.in_x = x; bus_a.in_y = y; bus_a.in_s = s;
    bus_a.in_r = r; bus_a.in_g = g; bus_a.in_b = b;
    bus_a.in_vld = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus_a.in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("send_a_timeout", {39'h0, bus_a.in_rdy}, 40'h1);
    end else begin
      @(posedge clk);
      #1;
    end
    bus_a.in_vld = 1'b0;
  endtask

  task automatic send_pix_a(input pix_t p);
    for (int s = 0; s < 4; s++) send_a(p.x, p.y, 2'(s), p.r[s], p.g[s], p.b[s]);
  endtask

  task automatic send_f(input logic [1:0] x, input logic y, input logic [1:0] s, input logic [15:0] v);
    int n;
    bus_f.in_x = x; bus_f.in_y = y; bus_f.in_s = s;
    bus_f.in_r = v; bus_f.in_g = v; bus_f.in_b = v;
    bus_f.in_vld = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus_f.in_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("send_f_timeout", {39'h0, bus_f.in_rdy}, 40'h1);
    end else begin
      @(posedge clk);
      #1;
    end
    bus_f.in_vld = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_vld"},    {39'h0, bus_a.out_vld},    40'h0);
    chk({tag, "_out_x"},      {32'h0, bus_a.out_x},      40'h0);
    chk({tag, "_out_y"},      {32'h0, bus_a.out_y},      40'h0);
    chk({tag, "_out_rgb"},    {16'h0, bus_a.out_rgb},    40'h0);
    chk({tag, "_seq_err"},    {39'h0, bus_a.seq_err},    40'h0);
    chk({tag, "_frame_done"}, {39'h0, bus_a.frame_done}, 40'h0);
    chk({tag, "_in_rdy"},     {39'h0, bus_a.in_rdy},     40'h1);
  endtask

  initial begin
    int base;
    int p;
    logic [23:0] v;

    tbl[0].x = 8'd3;   tbl[0].y = 8'd5;
    tbl[0].r = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
    tbl[0].g = {16'h2000, 16'h2000, 16'h2000, 16'h2000};
    tbl[0].b = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[0].rgb = 24'h804000;
    tbl[1].x = 8'd7;   tbl[1].y = 8'd2;
    tbl[1].r = {16'h8000, 16'h8000, 16'hFFFF, 16'h8000};
    tbl[1].g = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    tbl[1].b = {16'h0080, 16'h0080, 16'h0080, 16'h0080};
    tbl[1].rgb = 24'hFFFF01;
    tbl[2].x = 8'd239; tbl[2].y = 8'd239;
    tbl[2].r = {16'h0300, 16'h0200, 16'h0100, 16'h0000};
    tbl[2].g = {16'h1234, 16'h1234, 16'h1234, 16'h1234};
    tbl[2].b = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[2].rgb = 24'h0324FF;
    tbl[3].x = 8'd0;   tbl[3].y = 8'd0;
    tbl[3].r = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    tbl[3].g = {16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF};
    tbl[3].b = {16'h8000, 16'h8000, 16'h8000, 16'h8000};
    tbl[3].rgb = 24'h0001FF;

    rst_n = 1'b0;
    bus_a.in_vld = 1'b0; bus_a.in_x = 8'd0; bus_a.in_y = 8'd0; bus_a.in_s = 2'd0;
    bus_a.in_r = 16'h0; bus_a.in_g = 16'h0; bus_a.in_b = 16'h0; bus_a.out_rdy = 1'b1;
    bus_f.in_vld = 1'b0; bus_f.in_x = 2'd0; bus_f.in_y = 1'b0; bus_f.in_s = 2'd0;
    bus_f.in_r = 16'h0; bus_f.in_g = 16'h0; bus_f.in_b = 16'h0; bus_f.out_rdy = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven pixels with out_rdy high: one-cycle latency and exactly one output each.
    for (int i = 0; i < 4; i++) begin
      base = got_a.size();
      send_pix_a(tbl[i]);
      chk($sformatf("tbl%0d_vld", i), {39'h0, bus_a.out_vld}, 40'h1);
      chk($sformatf("tbl%0d_x", i),   {32'h0, bus_a.out_x},   {32'h0, tbl[i].x});
      chk($sformatf("tbl%0d_y", i),   {32'h0, bus_a.out_y},   {32'h0, tbl[i].y});
      chk($sformatf("tbl%0d_rgb", i), {16'h0, bus_a.out_rgb}, {16'h0, tbl[i].rgb});
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_count", i), 40'(got_a.size() - base), 40'd1);
    end
    chk("seq_err_clean", {39'h0, bus_a.seq_err}, 40'h0);

    // Backpressure: two pixels fill the FIFO, the third stalls until out_rdy rises.
    bus_a.out_rdy = 1'b0;
    base = got_a.size();
    send_pix_a(tbl[1]);
    send_pix_a(tbl[2]);
    chk("bp_full_rdy", {39'h0, bus_a.in_rdy}, 40'h0);
    fork
      send_pix_a(tbl[3]);
      begin
        repeat (3) @(negedge clk);
        chk("bp_stall_rdy", {39'h0, bus_a.in_rdy},  40'h0);
        chk("bp_hold_vld",  {39'h0, bus_a.out_vld}, 40'h1);
        chk("bp_hold_x",    {32'h0, bus_a.out_x},   {32'h0, tbl[1].x});
        chk("bp_hold_rgb",  {16'h0, bus_a.out_rgb}, {16'h0, tbl[1].rgb});
        chk("bp_no_xfer",   40'(got_a.size() - base), 40'd0);
        @(posedge clk); #1;
        bus_a.out_rdy = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("bp_count", 40'(got_a.size() - base), 40'd3);
    for (int i = 0; i < 3; i++) begin
      v = tbl[i + 1].rgb;
      chk($sformatf("bp_order%0d", i),
          (got_a.size() > base + i) ? got_a[base + i] : 40'h0,
          {tbl[i + 1].x, tbl[i + 1].y, v});
    end

    // Sequence errors: skipped index, then a good pixel, then a coordinate change.
    base = got_a.size();
    send_a(8'd10, 8'd10, 2'd0, 16'h1000, 16'h1000, 16'h1000);
    chk("seq_pre", {39'h0, bus_a.seq_err}, 40'h0);
    send_a(8'd10, 8'd10, 2'd2, 16'h1000, 16'h1000, 16'h1000);
    chk("seq_skip_err", {39'h0, bus_a.seq_err}, 40'h1);
    send_pix_a(tbl[0]);
    chk("seq_good_rgb", {16'h0, bus_a.out_rgb}, {16'h0, tbl[0].rgb});
    repeat (3) @(posedge clk);
    #1;
    chk("seq_good_count", 40'(got_a.size() - base), 40'd1);
    chk("seq_sticky",     {39'h0, bus_a.seq_err}, 40'h1);
    send_a(8'd20, 8'd4, 2'd0, 16'h2000, 16'h2000, 16'h2000);
    send_a(8'd21, 8'd4, 2'd1, 16'h2000, 16'h2000, 16'h2000);
    send_a(8'd21, 8'd4, 2'd2, 16'h2000, 16'h2000, 16'h2000);
    send_a(8'd21, 8'd4, 2'd3, 16'h2000, 16'h2000, 16'h2000);
    repeat (3) @(posedge clk);
    #1;
    chk("seq_xdiff_count", 40'(got_a.size() - base), 40'd1);

    // Reset in the middle of a pixel with one pixel still buffered.
    bus_a.out_rdy = 1'b0;
    send_pix_a(tbl[2]);
    send_a(tbl[3].x, tbl[3].y, 2'd0, tbl[3].r[0], tbl[3].g[0], tbl[3].b[0]);
    send_a(tbl[3].x, tbl[3].y, 2'd1, tbl[3].r[1], tbl[3].g[1], tbl[3].b[1]);
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_a.out_rdy = 1'b1;
    base = got_a.size();
    send_pix_a(tbl[1]);
    chk("post_rst_vld", {39'h0, bus_a.out_vld}, 40'h1);
    chk("post_rst_rgb", {16'h0, bus_a.out_rgb}, {16'h0, tbl[1].rgb});
    chk("post_rst_err", {39'h0, bus_a.seq_err}, 40'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_count", 40'(got_a.size() - base), 40'd1);

    // Full 4x2 frame on the small instance: frame_done only after (3,1) leaves.
    for (p = 0; p < 8; p++) begin
      for (int s = 0; s < 4; s++) send_f(2'(p % 4), 1'(p / 4), 2'(s), 16'((p + 1) * 16'h0800));
      if (p == 6) begin
        repeat (2) @(posedge clk);
        #1;
        chk("fd_early", 40'(fd_cnt), 40'd0);
      end
    end
    chk("fd_last_vld", {39'h0, bus_f.out_vld},    40'h1);
    chk("fd_not_yet",  {39'h0, bus_f.frame_done}, 40'h0);
    @(posedge clk); #1;
    chk("fd_pulse",    {39'h0, bus_f.frame_done}, 40'h1);
    @(posedge clk); #1;
    chk("fd_one_cyc",  {39'h0, bus_f.frame_done}, 40'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("fd_total",    40'(fd_cnt),    40'd1);
    chk("fd_pixels",   40'(got_f_cnt), 40'd8);
    chk("fd_last_rgb", {16'h0, got_f_last}, {16'h0, 24'h808080});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
